// File: rtl/sisc_ifetch.sv
// SISC instruction fetch: PC, synchronous imem reads, two-entry
// prefetch buffer, valid/ready delivery and branch redirect.
module sisc_ifetch #(
  parameter int          ADDR_W   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_f,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr
);

  logic [ADDR_W-1:0] r_fa;
  logic [ADDR_W-1:0] r_out_pc;
  logic              r_out;
  logic              r_kill;
  logic [1:0]        r_cnt;
  logic [31:0]       r_ins0;
  logic [31:0]       r_ins1;
  logic [ADDR_W-1:0] r_pc0;
  logic [ADDR_W-1:0] r_pc1;

  logic              w_accept;
  logic              w_issue;
  logic              w_push;
  logic [2:0]        w_occ;

  assign w_accept = ir_valid & ir_ready;

  // Slots committed after this edge: buffered + in flight - leaving.
  assign w_occ = {1'b0, r_cnt}
               + {2'b00, r_out}
               - {2'b00, w_accept};

  assign w_issue = ~rst_f & ~br_taken & (w_occ < 3'd2);
  assign w_push  = r_out & ~r_kill & ~br_taken;

  assign imem_rd   = w_issue;
  assign imem_addr = w_issue ? r_fa : '0;

  assign ir_valid = (r_cnt != 2'd0);
  assign ir       = ir_valid ? r_ins0 : '0;
  assign ir_pc    = ir_valid ? r_pc0 : '0;

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      r_fa     <= ADDR_W'(RESET_PC);
      r_out    <= 1'b0;
      r_out_pc <= '0;
      r_kill   <= 1'b0;
    end else begin
      r_out  <= w_issue;
      r_kill <= br_taken ? r_out : 1'b0;
      if (br_taken) begin
        r_fa <= br_addr;
      end else if (w_issue) begin
        r_fa     <= r_fa + 1'b1;
        r_out_pc <= r_fa;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      r_cnt  <= 2'd0;
      r_ins0 <= '0;
      r_ins1 <= '0;
      r_pc0  <= '0;
      r_pc1  <= '0;
    end else if (br_taken) begin
      r_cnt <= 2'd0;
    end else begin
      case ({w_push, w_accept})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_ins0 <= imem_data;
            r_pc0  <= r_out_pc;
          end else begin
            r_ins1 <= imem_data;
            r_pc1  <= r_out_pc;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_ins0 <= r_ins1;
          r_pc0  <= r_pc1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_ins0 <= imem_data;
            r_pc0  <= r_out_pc;
          end else begin
            r_ins0 <= r_ins1;
            r_pc0  <= r_pc1;
            r_ins1 <= imem_data;
            r_pc1  <= r_out_pc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sisc_ifetch.sv
// Bench for sisc_ifetch: scoreboard of expected pcs, popped on
// every accept; plus cycle-exact latency, stall and redirect checks.
module tb_sisc_ifetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_f;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        br_taken;
  logic [15:0] br_addr;

  logic        w_rd;
  logic [3:0]  w_addr;
  logic [31:0] w_data;
  logic [31:0] w_ir;
  logic [3:0]  w_pc;
  logic        w_valid;
  logic        w_rdy = 1'b1;
  logic        w_br  = 1'b0;
  logic [3:0]  w_ba  = 4'h0;

  sisc_ifetch #(.ADDR_W(16), .RESET_PC(0)) u_dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .imem_rd   (imem_rd),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .ir        (ir),
    .ir_pc     (ir_pc),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .br_taken  (br_taken),
    .br_addr   (br_addr)
  );

  sisc_ifetch #(.ADDR_W(4), .RESET_PC(14)) u_wrap (
    .clk       (clk),
    .rst_f     (rst_f),
    .imem_rd   (w_rd),
    .imem_addr (w_addr),
    .imem_data (w_data),
    .ir        (w_ir),
    .ir_pc     (w_pc),
    .ir_valid  (w_valid),
    .ir_ready  (w_rdy),
    .br_taken  (w_br),
    .br_addr   (w_ba)
  );

  // Synchronous memories; garbage when no read was issued.
  always @(posedge clk)
    imem_data <= imem_rd ? 32'hA000_0000 + {16'h0, imem_addr}
                         : 32'hDEAD_BEEF;

  always @(posedge clk)
    w_data <= w_rd ? 32'hB000_0000 + {28'h0, w_addr}
                   : 32'hDEAD_BEEF;

  int n_chk  = 0;
  int n_pass = 0;
  int unsigned sb[$];
  int unsigned wq[$];
  bit wen = 1'b0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mon();
    int unsigned e;
    @(negedge clk);
    if (ir_valid && ir_ready) begin
      if (sb.size() == 0) begin
        chk("sb_extra", {48'h0, ir_pc}, 64'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("pc", {48'h0, ir_pc}, {48'h0, e[15:0]});
        chk("ir", {32'h0, ir}, {32'h0, 32'hA000_0000 + e});
      end
    end
    if (wen && w_valid) begin
      if (wq.size() == 0) begin
        chk("wq_extra", {60'h0, w_pc}, 64'hFF);
      end else begin
        e = wq.pop_front();
        chk("w_pc", {60'h0, w_pc}, {60'h0, e[3:0]});
        chk("w_ir", {32'h0, w_ir}, {32'h0, 32'hB000_0000 + e});
      end
    end
  endtask

  task automatic sb_load(input int unsigned base);
    sb.delete();
    for (int k = 0; k < 40; k++) sb.push_back((base + k) & 16'hFFFF);
  endtask

  task automatic do_branch(input logic [15:0] at_pc,
                           input logic [15:0] tgt,
                           input logic        rdy);
    bit found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cyc();
      if (ir_valid && ir_pc == at_pc) found = 1'b1;
      else mon();
    end
    chk("br_find", {48'h0, ir_pc}, {48'h0, at_pc});
    br_taken = 1'b1;
    br_addr  = tgt;
    ir_ready = rdy;
    mon();
    chk("br_rd", {63'h0, imem_rd}, 64'h0);
    sb_load(tgt);
    cyc();
    br_taken = 1'b0;
    ir_ready = 1'b1;
    mon();
    chk("br_n1_valid", {63'h0, ir_valid}, 64'h0);
    chk("br_n1_rd", {63'h0, imem_rd}, 64'h1);
    chk("br_n1_addr", {48'h0, imem_addr}, {48'h0, tgt});
    cyc();
    mon();
    chk("br_n2_valid", {63'h0, ir_valid}, 64'h0);
    cyc();
    mon();
    chk("br_n3_valid", {63'h0, ir_valid}, 64'h1);
    chk("br_n3_pc", {48'h0, ir_pc}, {48'h0, tgt});
  endtask

  initial begin
    rst_f    = 1'b1;
    ir_ready = 1'b0;
    br_taken = 1'b0;
    br_addr  = 16'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rd", {63'h0, imem_rd}, 64'h0);
    chk("rst_addr", {48'h0, imem_addr}, 64'h0);
    chk("rst_ir", {32'h0, ir}, 64'h0);
    chk("rst_pc", {48'h0, ir_pc}, 64'h0);
    chk("rst_valid", {63'h0, ir_valid}, 64'h0);

    // Reset release and streaming, plus wrap-around instance.
    cyc();
    rst_f    = 1'b0;
    ir_ready = 1'b1;
    sb_load(0);
    wq.delete();
    for (int k = 0; k < 6; k++) wq.push_back((14 + k) % 16);
    wen = 1'b1;
    mon();
    chk("c1_rd", {63'h0, imem_rd}, 64'h1);
    chk("c1_addr", {48'h0, imem_addr}, 64'h0);
    chk("c1_valid", {63'h0, ir_valid}, 64'h0);
    cyc();
    mon();
    chk("c2_valid", {63'h0, ir_valid}, 64'h0);
    chk("c2_addr", {48'h0, imem_addr}, 64'h1);
    cyc();
    mon();
    chk("c3_valid", {63'h0, ir_valid}, 64'h1);
    chk("w_c3_valid", {63'h0, w_valid}, 64'h1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      mon();
      chk("stream_valid", {63'h0, ir_valid}, 64'h1);
      chk("wrap_valid", {63'h0, w_valid}, 64'h1);
    end
    wen = 1'b0;

    // Backpressure from the first valid cycle.
    cyc();
    rst_f = 1'b1;
    cyc();
    rst_f    = 1'b0;
    ir_ready = 1'b0;
    sb_load(0);
    mon();
    chk("bp_rd1", {63'h0, imem_rd}, 64'h1);
    chk("bp_addr1", {48'h0, imem_addr}, 64'h0);
    cyc();
    mon();
    chk("bp_rd2", {63'h0, imem_rd}, 64'h1);
    chk("bp_addr2", {48'h0, imem_addr}, 64'h1);
    cyc();
    mon();
    chk("bp_valid", {63'h0, ir_valid}, 64'h1);
    chk("bp_rd3", {63'h0, imem_rd}, 64'h0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      mon();
      chk("stall_rd", {63'h0, imem_rd}, 64'h0);
      chk("stall_pc", {48'h0, ir_pc}, 64'h0);
      chk("stall_ir", {32'h0, ir}, 64'hA000_0000);
    end
    cyc();
    ir_ready = 1'b1;
    mon();
    chk("rel_rd", {63'h0, imem_rd}, 64'h1);
    chk("rel_addr", {48'h0, imem_addr}, 64'h2);

    // Redirect with a read in flight, then redirect with accept.
    do_branch(16'h0005, 16'h0040, 1'b0);
    do_branch(16'h0043, 16'h0080, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      mon();
    end

    // Asynchronous reset between edges with two buffered.
    cyc();
    ir_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mon();
      cyc();
    end
    @(negedge clk);
    chk("pre_rst_valid", {63'h0, ir_valid}, 64'h1);
    #2 rst_f = 1'b1;
    #1;
    chk("arst_valid", {63'h0, ir_valid}, 64'h0);
    chk("arst_ir", {32'h0, ir}, 64'h0);
    chk("arst_rd", {63'h0, imem_rd}, 64'h0);
    cyc();
    rst_f    = 1'b0;
    ir_ready = 1'b1;
    sb_load(0);
    mon();
    chk("rs_rd", {63'h0, imem_rd}, 64'h1);
    chk("rs_addr", {48'h0, imem_addr}, 64'h0);
    cyc();
    mon();
    chk("rs_c2_valid", {63'h0, ir_valid}, 64'h0);
    cyc();
    mon();
    chk("rs_c3_valid", {63'h0, ir_valid}, 64'h1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      mon();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sisc_ifetch.md
# sisc_ifetch

Instruction fetch unit for the SISC processor. It owns the program counter and reads a synchronous instruction memory through a two-entry prefetch buffer. It presents the 32-bit instruction word `ir` to the `sisc` datapath/ctrl with a valid/ready handshake. It accepts branch redirects from ctrl and flushes stale fetches.

## Interface
- `ADDR_W`, 16, instruction address width in words; fetch address wraps modulo 2^ADDR_W
- `RESET_PC`, 0, first fetch address after reset
- `clk` input 1: single clock; all state updates on the rising edge
- `rst_f` input 1: reset, asynchronous, active-high
- `imem_rd` output 1: read strobe to instruction memory
- `imem_addr` output ADDR_W: read address, valid while `imem_rd`=1
- `imem_data` input 32: read data, valid exactly one cycle after the `imem_rd` cycle
- `ir` output 32: instruction at buffer head; 0 when `ir_valid`=0
- `ir_pc` output ADDR_W: address of `ir`; 0 when `ir_valid`=0
- `ir_valid` output 1: `ir`/`ir_pc` hold a live instruction
- `ir_ready` input 1: ctrl consumes the head this cycle when `ir_valid`=1 (accept)
- `br_taken` input 1: redirect fetch this cycle
- `br_addr` input ADDR_W: redirect target

## Operation
- State:
  - fetch address `fa`
  - 2-entry FIFO of {instr, pc}, with `count` 0..2
  - in-flight flag `out` (0/1), with its pc tag
  - kill flag
- `accept` = `ir_valid & ir_ready`.
- Issue rule: `imem_rd` = !`br_taken` & (`count` + `out` − `accept` < 2). On issue, `imem_addr`=`fa`; `fa` <= `fa`+1 (wraps).
- Response: in the cycle after an issue, `imem_data` is pushed with its pc tag, unless kill is set. A killed response is dropped.
- Pop on `accept`. Push and pop may occur in the same cycle; `count` is then unchanged.
- Redirect (`br_taken`=1):
  - FIFO flushed (`count` <= 0) at the edge.
  - kill <= `out`, so an in-flight read is dropped on return.
  - `fa` <= `br_addr`.
  - No issue in that cycle.
  - Any returning response in that cycle is dropped.
- Redirect and `accept` in the same cycle: the head is consumed, then the flush applies. Redirect has priority over any push.
- `ir_valid` = (`count`>0). While `ir_valid`=1 and `ir_ready`=0, `ir` and `ir_pc` are held stable.
- FIFO never overflows; the issue rule guarantees `count` + `out` ≤ 2 at every edge.

## Timing
- Reset values:
  - `imem_rd`=0
  - `imem_addr`=0
  - `ir`=0, `ir_pc`=0
  - `ir_valid`=0
  - `fa`=`RESET_PC`, `count`=0, `out`=0, kill=0
- Reset mid-operation: all state is cleared asynchronously and any in-flight response is ignored. The first cycle after deassertion behaves as cycle 1 below.
- First cycle after reset deassert (cycle 1): `imem_rd`=1 with `imem_addr`=`RESET_PC`. Data is pushed at the end of cycle 2. `ir_valid`=1 in cycle 3.
- Sustained throughput is 1 instruction/cycle with `ir_ready` held at 1.
- Branch penalty, with `br_taken` in cycle N:
  - `imem_rd` at `br_addr` in N+1
  - `ir_valid` with `ir_pc`=`br_addr` in N+3
  - `ir_valid`=0 in N+1 and N+2
- Stall: with `ir_ready`=0, at most two instructions are buffered, then `imem_rd` stays 0. When `ir_ready` rises, `imem_rd` reasserts in that same cycle.
- Wrap-around: the issue after `fa`=2^ADDR_W−1 is at address 0; no gap cycle.

## Test plan
- Reset and streaming:
  - Stimulus: memory holds word[i]=0xA000_0000+i; RESET_PC=0; `ir_ready`=1.
  - Required: `imem_rd` high from cycle 1; `ir_valid` from cycle 3; `ir_pc` = 0,1,2,… with `ir`=0xA000_0000+`ir_pc` every cycle.
- Backpressure:
  - Stimulus: `ir_ready`=0 for 5 cycles once `ir_valid` rises.
  - Required: `ir`/`ir_pc` frozen at pc 0; exactly two reads issued (addr 0,1), then `imem_rd`=0. On release, pcs 0,1,2,… are accepted with no loss or duplicate.
- Branch:
  - Stimulus: `br_taken`=1, `br_addr`=0x0040 while pc 5 is at head and a read is in flight.
  - Required: `ir_valid`=0 for 2 cycles, then `ir_pc`=0x0040. No pc 6/7 ever appears at the head after the branch.
- Branch with simultaneous accept:
  - Stimulus: `ir_ready`=1 and `br_taken`=1 in the same cycle.
  - Required: the head counts as consumed; the next valid instruction is at `br_addr`; FIFO `count` never exceeds 2.
- Wrap-around:
  - Stimulus: ADDR_W=4, RESET_PC=14, `ir_ready`=1.
  - Required: `ir_pc` sequence 14,15,0,1 with no bubble.
- Reset mid-operation:
  - Stimulus: assert `rst_f` asynchronously between edges while two instructions are buffered.
  - Required: `ir_valid`=0, `ir`=0 and `imem_rd`=0 immediately. After deassert, fetch restarts at RESET_PC and the pre-reset in-flight datum is never presented.
